imem_loader: RTL and testbench

Program loader for the single-cycle core's instruction memory. It accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit instruction words. It writes those words sequentially from byte address 0 into the instruction memory's write port. It raises `run` when the image is complete, so the core's active-low reset can be released only after the program is in place.

---
 rtl/imem_loader_if.sv | 26 ++
 rtl/imem_loader.sv | 96 +++++++++
 tb/tb_imem_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Host-side load bus for imem_loader: the byte stream in, the instruction-memory write port
// out, and load status.
interface imem_loader_if #(
  parameter int LEN_W = 11
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             we;
  logic [31:0]      waddr;
  logic [31:0]      wdata;
  logic             busy;
  logic             run;

  modport master (
    output start, len, in_data, in_valid,
    input  in_ready, we, waddr, wdata, busy, run
  );

  modport slave (
    input  start, len, in_data, in_valid,
    output in_ready, we, waddr, wdata, busy, run
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them sequentially from
// address 0. It raises run once the image is complete.
module imem_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      waddr_q, waddr_d;
  logic             we_q, we_d;

  // Requested lengths larger than the memory are clamped so waddr can never overflow.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : l;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      wdata_q    <= '0;
      waddr_q    <= '0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      waddr_q    <= waddr_d;
      we_q       <= we_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    waddr_d    = waddr_q;
    we_d       = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            byte_cnt_d = '0;
            word_cnt_d = '0;
            len_d      = clamp_len(bus.len);
            state_d    = RECV;
          end else begin
            state_d    = DONE;
          end
        end
      end
      RECV: begin
        if (bus.in_valid) begin
          // Shift in from the top so the first byte ends up in [7:0] after four bytes.
          wdata_d    = {bus.in_data, wdata_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = WRITE;
            we_d    = 1'b1;
            waddr_d = 32'({word_cnt_q[ADDR_W-1:0], 2'b00});
          end
        end
      end
      WRITE: begin
        word_cnt_d = word_cnt_q + LEN_W'(1);
        state_d    = (word_cnt_d == len_q) ? DONE : RECV;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready = (state_q == RECV);
  assign bus.busy     = (state_q == RECV) || (state_q == WRITE);
  assign bus.run      = (state_q == DONE);
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed-sequence bench for imem_loader with random byte streams and a word-list reference model.
module tb_imem_loader;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if #(.LEN_W(LEN_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  stim[$];
  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];

  // Every write the memory would capture, in order.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      cap_addr.push_back(bus.waddr);
      cap_data.push_back(bus.wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic gen_bytes(input int n);
    stim.delete();
    repeat (n) stim.push_back(8'($urandom));
  endtask

  task automatic clear_caps();
    cap_addr.delete();
    cap_data.delete();
  endtask

  task automatic pulse_start(input int l);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = LEN_W'(l);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Offers stim[first +: n] starting at the current negedge; returns at the negedge of the
  // cycle after the last byte was accepted.
  task automatic send(input int first, input int n, input bit gaps);
    int idx = first;
    int budget = 0;
    while (idx < first + n && budget < 20000) begin
      bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = bus.in_valid ? stim[idx] : 8'($urandom);
      if (bus.in_valid && bus.in_ready === 1'b1) idx++;
      @(posedge clk);
      @(negedge clk);
      budget++;
    end
    bus.in_valid = 1'b0;
    check("bytes_accepted", 32'(idx), 32'(first + n));
  endtask

  // Expected image: word i at byte address 4*i, built little-endian from stream bytes base+4*i..
  task automatic verify(input string tag, input int nwords, input int base);
    logic [31:0] exp_data;
    check({tag, "_count"}, 32'(cap_addr.size()), 32'(nwords));
    for (int i = 0; i < nwords && i < cap_addr.size(); i++) begin
      exp_data = {stim[base+4*i+3], stim[base+4*i+2], stim[base+4*i+1], stim[base+4*i]};
      check({tag, "_addr"}, cap_addr[i], 32'(4 * i));
      check({tag, "_data"}, cap_data[i], exp_data);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.len = '0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hA5;

    // Reset held with a byte on offer
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_waddr", bus.waddr, 32'd0);
    check("rst_wdata", bus.wdata, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_run", 32'(bus.run), 32'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_no_write", 32'(cap_addr.size()), 32'd0);

    // Two-word load, back to back
    stim = '{8'h03, 8'hA3, 8'hC4, 8'hFF, 8'h23, 8'h24, 8'hB6, 8'h00};
    clear_caps();
    pulse_start(2);
    check("ready_after_start", 32'(bus.in_ready), 32'd1);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    send(0, 4, 1'b0);
    check("w0_we", 32'(bus.we), 32'd1);
    check("w0_waddr", bus.waddr, 32'h0);
    check("w0_wdata", bus.wdata, 32'hFFC4A303);
    check("w0_ready_low", 32'(bus.in_ready), 32'd0);
    send(4, 4, 1'b0);
    check("w1_we", 32'(bus.we), 32'd1);
    check("w1_waddr", bus.waddr, 32'h4);
    check("w1_wdata", bus.wdata, 32'h00B62423);
    check("w1_run_low", 32'(bus.run), 32'd0);
    @(negedge clk);
    check("two_run", 32'(bus.run), 32'd1);
    check("two_busy", 32'(bus.busy), 32'd0);
    check("two_we_low", 32'(bus.we), 32'd0);
    verify("two", 2, 0);

    // Same stream with random valid gaps, restarted from DONE
    clear_caps();
    pulse_start(2);
    check("gap_run_drop", 32'(bus.run), 32'd0);
    send(0, 8, 1'b1);
    check("gap_we", 32'(bus.we), 32'd1);
    @(negedge clk);
    check("gap_run", 32'(bus.run), 32'd1);
    verify("gap", 2, 0);

    // Zero length from IDLE and from DONE
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("zero_run_before", 32'(bus.run), 32'd0);
    clear_caps();
    pulse_start(0);
    check("zero_run", 32'(bus.run), 32'd1);
    check("zero_we", 32'(bus.we), 32'd0);
    pulse_start(0);
    check("zero_done_run", 32'(bus.run), 32'd1);
    repeat (3) @(negedge clk);
    check("zero_no_write", 32'(cap_addr.size()), 32'd0);

    // Oversized length clamps to DEPTH words
    gen_bytes(4 * DEPTH);
    clear_caps();
    pulse_start(2000);
    send(0, 4 * DEPTH, 1'b0);
    check("clamp_last_we", 32'(bus.we), 32'd1);
    check("clamp_last_waddr", bus.waddr, 32'hFFC);
    @(negedge clk);
    check("clamp_run", 32'(bus.run), 32'd1);
    verify("clamp", DEPTH, 0);

    // Reset in the middle of a four-word load
    gen_bytes(16);
    clear_caps();
    pulse_start(4);
    send(0, 6, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h5A;
    repeat (10) @(negedge clk);
    check("abort_ready", 32'(bus.in_ready), 32'd0);
    check("abort_run", 32'(bus.run), 32'd0);
    bus.in_valid = 1'b0;
    verify("abort", 1, 0);
    clear_caps();
    pulse_start(1);
    send(6, 4, 1'b0);
    check("reload_we", 32'(bus.we), 32'd1);
    check("reload_waddr", bus.waddr, 32'h0);
    check("reload_wdata", bus.wdata, {stim[9], stim[8], stim[7], stim[6]});
    @(negedge clk);
    check("reload_run", 32'(bus.run), 32'd1);
    verify("reload", 1, 6);

    // start while a three-word load is running is ignored
    gen_bytes(12);
    clear_caps();
    pulse_start(3);
    send(0, 5, 1'b0);
    bus.start = 1'b1;
    bus.len = LEN_W'(1);
    @(negedge clk);
    bus.start = 1'b0;
    send(5, 7, 1'b0);
    check("busy_start_we", 32'(bus.we), 32'd1);
    check("busy_start_waddr", bus.waddr, 32'h8);
    check("busy_start_run_low", 32'(bus.run), 32'd0);
    @(negedge clk);
    check("busy_start_run", 32'(bus.run), 32'd1);
    verify("busy_start", 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
